// File: rtl/flow_ctrl_pkg.sv
// Shared types and defaults for the pipeline flow controller.
package flow_ctrl_pkg;

  // FSM encodings are fixed so that the other pipeline blocks can decode them.
  typedef enum logic [1:0] {
    FC_RUN      = 2'd0,
    FC_REPLAY   = 2'd1,
    FC_WAIT_DIV = 2'd2
  } fc_state_e;

  localparam int FC_ADDR_W_DEF      = 32;
  localparam int FC_CNT_W_DEF       = 32;
  localparam int FC_DIV_TIMEOUT_DEF = 64;

  // Index of each performance counter in the counter bank.
  localparam int FC_PERF_STALL = 0;
  localparam int FC_PERF_FLUSH = 1;
  localparam int FC_PERF_NUM   = 2;

  // Per-cycle pipeline control bundle. The jump address travels separately.
  typedef struct packed {
    logic jump;
    logic flush_ifid;
    logic bk_ifid;
    logic flush_idex;
    logic hold_pc;
    logic stall;
  } fc_ctrl_t;

endpackage

// File: rtl/fc_perf_cnt.sv
// Free-running event counter; wraps modulo 2^CNT_W and never saturates.
module fc_perf_cnt
  import flow_ctrl_pkg::*;
#(
  parameter int CNT_W = FC_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_reg;

  // Count one per cycle with inc_i high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (inc_i) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/flow_ctrl.sv
// Pipeline flow controller: priority-decodes hazard/redirect requests into
// PC / IF/ID / ID/EX controls, sequences load-use replay and divide stalls,
// and keeps stall/flush performance counters.
module flow_ctrl
  import flow_ctrl_pkg::*;
#(
  parameter int ADDR_W      = FC_ADDR_W_DEF,
  parameter int CNT_W       = FC_CNT_W_DEF,
  parameter int DIV_TIMEOUT = FC_DIV_TIMEOUT_DEF  // must be >= 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_load_use_i,
  input  logic              ex_jump_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              ex_div_start_i,
  input  logic              div_done_i,
  input  logic              mem_wait_i,
  output logic              fc_jump_o,
  output logic [ADDR_W-1:0] fc_jump_addr_o,
  output logic              fc_flush_ifid_o,
  output logic              fc_bk_ifid_o,
  output logic              fc_flush_idex_o,
  output logic              fc_hold_pc_o,
  output logic              fc_stall_o,
  output logic              fc_err_o,
  output logic [CNT_W-1:0]  fc_stall_cnt_o,
  output logic [CNT_W-1:0]  fc_flush_cnt_o
);

  localparam int                   DIV_CNT_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [DIV_CNT_W-1:0] DIV_LIMIT = DIV_CNT_W'(DIV_TIMEOUT);

  fc_state_e              state_reg, state_next;
  logic [DIV_CNT_W-1:0]   div_cnt_reg, div_cnt_next, div_cnt_inc;
  logic                   err_reg, err_next;
  fc_ctrl_t               ctrl;
  logic [ADDR_W-1:0]      jump_addr;
  logic [FC_PERF_NUM-1:0] perf_inc;
  logic [CNT_W-1:0]       perf_cnt [FC_PERF_NUM];

  // State, divide cycle counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FC_RUN;
      div_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      err_reg     <= err_next;
    end
  end

  // Priority decode: mem_wait > divide wait > jump > divide start > load-use.
  // The divide counter holds the number of stall cycles already spent on the
  // current divide (the start cycle counts as 1), so the abort fires on the
  // cycle that would bring it to DIV_TIMEOUT: exactly DIV_TIMEOUT stall cycles.
  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    err_next     = err_reg;
    ctrl         = '0;
    jump_addr    = '0;
    div_cnt_inc  = div_cnt_reg + DIV_CNT_W'(1);

    if (!rst_n) begin
      // Hold every control low while reset is asserted, independent of inputs.
      ctrl = '0;
    end else if (mem_wait_i) begin
      // Whole pipe frozen; all other requests must be re-presented later.
      ctrl.stall = 1'b1;
    end else begin
      case (state_reg)
        FC_WAIT_DIV: begin
          if (div_done_i) begin
            // Result ready: release this cycle, any jump request is ignored.
            div_cnt_next = '0;
            state_next   = FC_RUN;
          end else begin
            ctrl.stall   = 1'b1;
            div_cnt_next = div_cnt_inc;
            if (div_cnt_inc == DIV_LIMIT) begin
              err_next     = 1'b1;
              div_cnt_next = '0;
              state_next   = FC_RUN;
            end
          end
        end

        FC_REPLAY: begin
          // Replay lasts one cycle; a jump here wins and suppresses the bk.
          state_next = FC_RUN;
          if (ex_jump_i) begin
            ctrl.jump       = 1'b1;
            ctrl.flush_ifid = 1'b1;
            ctrl.flush_idex = 1'b1;
            jump_addr       = ex_jump_addr_i;
          end else begin
            ctrl.bk_ifid = 1'b1;
          end
        end

        default: begin
          // FC_RUN; the unused encoding also lands here and recovers to RUN.
          state_next = FC_RUN;
          if (ex_jump_i) begin
            ctrl.jump       = 1'b1;
            ctrl.flush_ifid = 1'b1;
            ctrl.flush_idex = 1'b1;
            jump_addr       = ex_jump_addr_i;
          end else if (ex_div_start_i) begin
            ctrl.stall   = 1'b1;
            div_cnt_next = DIV_CNT_W'(1);
            state_next   = FC_WAIT_DIV;
          end else if (id_load_use_i) begin
            ctrl.flush_idex = 1'b1;
            ctrl.hold_pc    = 1'b1;
            state_next      = FC_REPLAY;
          end
        end
      endcase
    end
  end

  assign perf_inc[FC_PERF_STALL] = ctrl.stall;
  assign perf_inc[FC_PERF_FLUSH] = ctrl.jump;

  // One counter per performance event.
  for (genvar gi = 0; gi < FC_PERF_NUM; gi++) begin : g_perf
    fc_perf_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (perf_inc[gi]),
      .cnt_o (perf_cnt[gi])
    );
  end

  assign fc_jump_o       = ctrl.jump;
  assign fc_jump_addr_o  = jump_addr;
  assign fc_flush_ifid_o = ctrl.flush_ifid;
  assign fc_bk_ifid_o    = ctrl.bk_ifid;
  assign fc_flush_idex_o = ctrl.flush_idex;
  assign fc_hold_pc_o    = ctrl.hold_pc;
  assign fc_stall_o      = ctrl.stall;
  assign fc_err_o        = err_reg;
  assign fc_stall_cnt_o  = perf_cnt[FC_PERF_STALL];
  assign fc_flush_cnt_o  = perf_cnt[FC_PERF_FLUSH];

endmodule

// File: tb/tb_flow_ctrl.sv
// Self-checking bench for flow_ctrl. Two instances share stimulus: "a" uses
// default parameters, "b" uses DIV_TIMEOUT=4 and a 4-bit counter for the
// timeout and wrap cases. Expected controls are queued when a cycle's inputs
// are driven and popped when the outputs are sampled.
module tb_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_load_use, ex_jump, ex_div_start, div_done, mem_wait;
  logic [31:0] ex_jump_addr;

  logic        a_jump, a_fi, a_bk, a_fx, a_hold, a_stall, a_err;
  logic [31:0] a_addr, a_stall_cnt, a_flush_cnt;
  logic        b_jump, b_fi, b_bk, b_fx, b_hold, b_stall, b_err;
  logic [31:0] b_addr;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic sel_b = 1'b0;

  typedef struct packed {
    logic        jump;
    logic [31:0] addr;
    logic        fi;
    logic        bk;
    logic        fx;
    logic        hold;
    logic        stall;
  } ctl_t;

  ctl_t exp_q[$];

  // Expected control codes: {jump, flush_ifid, bk_ifid, flush_idex, hold_pc, stall}
  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_STALL = 6'b000001;
  localparam logic [5:0] E_LU    = 6'b000110;
  localparam logic [5:0] E_BK    = 6'b001000;
  localparam logic [5:0] E_JMP   = 6'b110100;

  always #5 clk = ~clk;

  flow_ctrl u_dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_load_use_i   (id_load_use),
    .ex_jump_i       (ex_jump),
    .ex_jump_addr_i  (ex_jump_addr),
    .ex_div_start_i  (ex_div_start),
    .div_done_i      (div_done),
    .mem_wait_i      (mem_wait),
    .fc_jump_o       (a_jump),
    .fc_jump_addr_o  (a_addr),
    .fc_flush_ifid_o (a_fi),
    .fc_bk_ifid_o    (a_bk),
    .fc_flush_idex_o (a_fx),
    .fc_hold_pc_o    (a_hold),
    .fc_stall_o      (a_stall),
    .fc_err_o        (a_err),
    .fc_stall_cnt_o  (a_stall_cnt),
    .fc_flush_cnt_o  (a_flush_cnt)
  );

  flow_ctrl #(
    .ADDR_W      (32),
    .CNT_W       (4),
    .DIV_TIMEOUT (4)
  ) u_dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_load_use_i   (id_load_use),
    .ex_jump_i       (ex_jump),
    .ex_jump_addr_i  (ex_jump_addr),
    .ex_div_start_i  (ex_div_start),
    .div_done_i      (div_done),
    .mem_wait_i      (mem_wait),
    .fc_jump_o       (b_jump),
    .fc_jump_addr_o  (b_addr),
    .fc_flush_ifid_o (b_fi),
    .fc_bk_ifid_o    (b_bk),
    .fc_flush_idex_o (b_fx),
    .fc_hold_pc_o    (b_hold),
    .fc_stall_o      (b_stall),
    .fc_err_o        (b_err),
    .fc_stall_cnt_o  (b_stall_cnt),
    .fc_flush_cnt_o  (b_flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the edge, queue the expectation, sample later.
  task automatic step(input string tag, input logic ld, input logic jmp,
                      input logic [31:0] addr, input logic ds, input logic dd,
                      input logic mw, input logic [5:0] e);
    ctl_t ex;
    ctl_t ob;
    @(posedge clk);
    #1;
    id_load_use  = ld;
    ex_jump      = jmp;
    ex_jump_addr = addr;
    ex_div_start = ds;
    div_done     = dd;
    mem_wait     = mw;
    ex = '{jump: e[5], addr: (e[5] ? addr : 32'h0), fi: e[4], bk: e[3],
           fx: e[2], hold: e[1], stall: e[0]};
    exp_q.push_back(ex);
    #3;
    if (sel_b) ob = {b_jump, b_addr, b_fi, b_bk, b_fx, b_hold, b_stall};
    else       ob = {a_jump, a_addr, a_fi, a_bk, a_fx, a_hold, a_stall};
    ex = exp_q.pop_front();
    check(tag, 64'(ob), 64'(ex));
    $display("%0t %s dut=%s in(ld=%0b j=%0b ds=%0b dd=%0b mw=%0b) ctl=%0h exp=%0h",
             $time, tag, sel_b ? "b" : "a", ld, jmp, ds, dd, mw, ob, ex);
  endtask

  task automatic pulse_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_a_ctl", 64'({a_jump, a_addr, a_fi, a_bk, a_fx, a_hold, a_stall}), 64'h0);
    check("rst_b_ctl", 64'({b_jump, b_addr, b_fi, b_bk, b_fx, b_hold, b_stall}), 64'h0);
    check("rst_cnts", 64'({a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt}), 64'h0);
    check("rst_err", 64'({a_err, b_err}), 64'h0);
    @(negedge clk);
    mem_wait = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    id_load_use = 1'b0; ex_jump = 1'b0; ex_jump_addr = 32'h0;
    ex_div_start = 1'b0; div_done = 1'b0; mem_wait = 1'b1;
    #2;
    check("init_ctl", 64'({a_jump, a_addr, a_fi, a_bk, a_fx, a_hold, a_stall}), 64'h0);
    check("init_cnts", 64'({a_stall_cnt, a_flush_cnt, a_err}), 64'h0);
    @(negedge clk);
    mem_wait = 1'b0;
    rst_n    = 1'b1;

    // Load-use replay sequence
    step("lu_c0", 1, 0, 32'h0, 0, 0, 0, E_LU);
    step("lu_c1", 0, 0, 32'h0, 0, 0, 0, E_BK);
    step("lu_c2", 0, 0, 32'h0, 0, 0, 0, E_NONE);

    // Jump wins over a same-cycle load-use
    step("jmp_lu", 1, 1, 32'h0000_0100, 0, 0, 0, E_JMP);
    step("jmp_after", 0, 0, 32'h0, 0, 0, 0, E_NONE);
    check("flush_cnt_1", 64'(a_flush_cnt), 64'd1);

    // Divide done five cycles after start; jump on the done cycle is ignored
    step("div_start", 0, 0, 32'h0, 1, 0, 0, E_STALL);
    for (int i = 0; i < 4; i++) step("div_wait", 0, 0, 32'h0, 0, 0, 0, E_STALL);
    step("div_done", 0, 1, 32'h0000_0200, 0, 1, 0, E_NONE);
    step("div_after", 0, 0, 32'h0, 0, 0, 0, E_NONE);
    check("stall_cnt_5", 64'(a_stall_cnt), 64'd5);
    check("flush_cnt_div", 64'(a_flush_cnt), 64'd1);
    step("div_run_lu", 1, 0, 32'h0, 0, 0, 0, E_LU);
    step("div_run_bk", 0, 0, 32'h0, 0, 0, 0, E_BK);

    // mem_wait during REPLAY with a pending jump
    step("mw_lu", 1, 0, 32'h0, 0, 0, 0, E_LU);
    for (int i = 0; i < 3; i++) step("mw_hold", 0, 1, 32'h0000_0300, 0, 0, 1, E_STALL);
    step("mw_rel_jmp", 0, 1, 32'h0000_0300, 0, 0, 0, E_JMP);
    step("mw_after", 0, 0, 32'h0, 0, 0, 0, E_NONE);
    check("flush_cnt_2", 64'(a_flush_cnt), 64'd2);
    check("stall_cnt_8", 64'(a_stall_cnt), 64'd8);
    check("err_a_clear", 64'(a_err), 64'd0);

    // Divide timeout on the DIV_TIMEOUT=4 instance
    pulse_reset();
    sel_b = 1'b1;
    step("to_start", 0, 0, 32'h0, 1, 0, 0, E_STALL);
    for (int i = 0; i < 3; i++) step("to_wait", 0, 0, 32'h0, 0, 0, 0, E_STALL);
    step("to_drop", 0, 0, 32'h0, 0, 0, 0, E_NONE);
    check("err_set", 64'(b_err), 64'd1);
    step("to_idle", 0, 0, 32'h0, 0, 0, 0, E_NONE);
    check("err_sticky", 64'(b_err), 64'd1);
    step("to_run_lu", 1, 0, 32'h0, 0, 0, 0, E_LU);
    step("to_run_bk", 0, 0, 32'h0, 0, 0, 0, E_BK);

    // Asynchronous reset in the middle of WAIT_DIV
    step("rst_div_start", 0, 0, 32'h0, 1, 0, 0, E_STALL);
    step("rst_div_wait", 0, 0, 32'h0, 0, 0, 0, E_STALL);
    mem_wait = 1'b1;
    pulse_reset();
    step("rst_post_b", 0, 0, 32'h0, 0, 0, 0, E_NONE);
    sel_b = 1'b0;
    step("rst_post_a", 0, 0, 32'h0, 0, 0, 0, E_NONE);

    // Stall counter wrap on the 4-bit instance
    sel_b = 1'b1;
    for (int i = 0; i < 15; i++) step("wrap_fill", 0, 0, 32'h0, 0, 0, 1, E_STALL);
    step("wrap_last", 0, 0, 32'h0, 0, 0, 1, E_STALL);
    check("stall_cnt_ones", 64'(b_stall_cnt), 64'hF);
    step("wrap_idle", 0, 0, 32'h0, 0, 0, 0, E_NONE);
    check("stall_cnt_wrap", 64'(b_stall_cnt), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
